alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the CPU's combinational ALU.
- Keeps the 5-bit opcode map and the {sign, zero, parity, carry} status vector.
- Adds a registered status flag register, so ADC/SBB consume the real stored carry.
- Adds variable-count shifts/rotates and an iterative multiplier, using a valid/ready issue handshake and a done pulse. Sits between the control unit and the register file.

Parameters:
- DATA_WIDTH, 8, operand/result width; must be a power of two, ≥4.
- SHAMT_W, $clog2(DATA_WIDTH), derived localparam; shift-count width.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE; transfer when in_valid && in_ready.
- opcode  in  5  operation code, captured on transfer.
- A  in  DATA_WIDTH  operand A, captured on transfer.
- B  in  DATA_WIDTH  operand B / shift count (B[SHAMT_W-1:0]), captured on transfer.
- done  out  1  one-cycle pulse; C, C_hi and status valid and held from then until next done.
- C  out  DATA_WIDTH  result (low half for MUL).
- C_hi  out  DATA_WIDTH  MUL high half; 0 for all other ops.
- status  out  4  registered flags {sign, zero, parity, carry}.

Behaviour:
- Reset (sync, any state including mid-op): state=IDLE; in_ready=1; done=0; C=0; C_hi=0; status=0000. In-flight op aborted with no done.
- FSM IDLE -> EXEC -> DONE -> IDLE:
  - IDLE: transfer captures operands; goes to EXEC.
  - EXEC: counts down iterations.
  - DONE: asserts done and writes C, C_hi and status the same edge; returns to IDLE. in_valid outside IDLE is ignored.
- Latency from transfer edge to done:
  - single-cycle ops: 2 cycles.
  - shifts/rotates: count+2 cycles.
  - MUL: DATA_WIDTH+2 cycles.
- Opcodes (W=DATA_WIDTH, arithmetic on W+1 bits, carry = bit W):
  - 00 LD C=A
  - 01 INC A+1
  - 02 ADD A+B
  - 03 ADC A+B+cf
  - 04 SBB A-B-cf
  - 05 SUB A-B
  - 06 DEC A-1
  - 07 LD1 C=A
  - 08/09 AND
  - 0A/0B OR
  - 0C/0D XOR
  - 0E/0F CMP C=~B
  - 10 RSH logical
  - 11 ASR
  - 18 LSH
  - 19 ROL
  - 14 MUL unsigned
  - Others: C=A, treated as LD.
  - cf = status[0] as registered before this op.
- Flags:
  - sign = C[W-1]; zero = (C==0); parity = ^C.
  - carry:
    - arithmetic: bit W, i.e. borrow for SUB/SBB/DEC.
    - logic/LD/CMP: 0.
    - shift/rotate: last bit shifted out; 0 if count=0.
    - MUL: (C_hi!=0).
- Shifts run one bit per EXEC cycle. count=0 gives C=A.
- MUL is shift-add, one bit per cycle; sign/zero/parity are computed on C only.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: opcode 14 runs the iterative multiplier described above.
- Undefined: multiplier hardware absent; opcode 14 acts as LD: C=A, C_hi=0, 2-cycle latency.

Decomposition:
- Shared package/header (alongside DATA_WIDTH defines):
  - opcode constants;
  - status bit indices SIGN=3, ZERO=2, PARITY=1, CARRY=0;
  - FSM state encodings.
- Sub-module alu_mc_core: combinational single-cycle op datapath plus flag generation, reused by the FSM wrapper.

Test Plan (DATA_WIDTH=8):
- reset; ADD A=200,B=100 -> done 2 cycles after transfer, C=44, status=0011.
- ADC A=1,B=1 immediately after previous -> C=3, status=0000.
- SUB A=5,B=5 -> C=0, status=0100; then SUB A=3,B=5 -> C=0xFE, status=1011; then SBB A=3,B=1 -> C=1, status=0010.
- LSH A=0x81,B=3 -> C=0x08, carry=0, done 5 cycles after transfer; ASR A=0x80,B=2 -> C=0xE0, status=1010; RSH B=0 -> C=A, 2-cycle latency.
- MUL A=200,B=3 with ALU_MUL_EN -> C=0x58, C_hi=0x02, status=0011, done 10 cycles after transfer; without macro -> C=200, C_hi=0.
- MUL started, reset asserted 4 cycles in -> next cycle in_ready=1, status=0000, no done; in_valid pulses during EXEC are never captured.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared opcode map, status bit indices, FSM encoding and op-class helpers for alu_mc.
// ALU_MUL_EN enables the iterative multiplier on opcode 14.
package alu_mc_pkg;

  localparam logic [4:0] OP_LD   = 5'h00;
  localparam logic [4:0] OP_INC  = 5'h01;
  localparam logic [4:0] OP_ADD  = 5'h02;
  localparam logic [4:0] OP_ADC  = 5'h03;
  localparam logic [4:0] OP_SBB  = 5'h04;
  localparam logic [4:0] OP_SUB  = 5'h05;
  localparam logic [4:0] OP_DEC  = 5'h06;
  localparam logic [4:0] OP_LD1  = 5'h07;
  localparam logic [4:0] OP_AND  = 5'h08;
  localparam logic [4:0] OP_AND1 = 5'h09;
  localparam logic [4:0] OP_OR   = 5'h0A;
  localparam logic [4:0] OP_OR1  = 5'h0B;
  localparam logic [4:0] OP_XOR  = 5'h0C;
  localparam logic [4:0] OP_XOR1 = 5'h0D;
  localparam logic [4:0] OP_CMP  = 5'h0E;
  localparam logic [4:0] OP_CMP1 = 5'h0F;
  localparam logic [4:0] OP_RSH  = 5'h10;
  localparam logic [4:0] OP_ASR  = 5'h11;
  localparam logic [4:0] OP_MUL  = 5'h14;
  localparam logic [4:0] OP_LSH  = 5'h18;
  localparam logic [4:0] OP_ROL  = 5'h19;

  localparam int SIGN   = 3;
  localparam int ZERO   = 2;
  localparam int PARITY = 1;
  localparam int CARRY  = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic sign;
    logic zero;
    logic parity;
    logic carry;
  } flags_t;

  function automatic logic is_shift(input logic [4:0] op);
    return (op == OP_RSH) || (op == OP_ASR) || (op == OP_LSH) || (op == OP_ROL);
  endfunction

  // Without the multiplier, opcode 14 falls through to the LD default path.
  function automatic logic is_mul(input logic [4:0] op);
`ifdef ALU_MUL_EN
    return op == OP_MUL;
`else
    return (op != op);
`endif
  endfunction

endpackage

// File: rtl/alu_mc_core.sv
// Combinational single-cycle datapath plus flag generation; iterative results
// (shift/rotate, multiply) are passed in and flagged through the same path.
module alu_mc_core
  import alu_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [4:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cf,
  input  logic                  iter_sel,
  input  logic [DATA_WIDTH-1:0] iter_c,
  input  logic                  iter_cy,
  output logic [DATA_WIDTH-1:0] c,
  output flags_t                flags
);

  localparam int W = DATA_WIDTH;

  logic [W:0]   ax, bx, cx, one, ext;
  logic [W-1:0] res;
  logic         arith;

  assign ax  = {1'b0, a};
  assign bx  = {1'b0, b};
  assign cx  = {{W{1'b0}}, cf};
  assign one = {{W{1'b0}}, 1'b1};

  // Arithmetic runs on W+1 bits so bit W is carry, or borrow on subtracts.
  always_comb begin
    ext   = '0;
    res   = a;
    arith = 1'b0;
    case (op)
      OP_INC:           begin ext = ax + one;      arith = 1'b1; end
      OP_ADD:           begin ext = ax + bx;       arith = 1'b1; end
      OP_ADC:           begin ext = ax + bx + cx;  arith = 1'b1; end
      OP_SBB:           begin ext = ax - bx - cx;  arith = 1'b1; end
      OP_SUB:           begin ext = ax - bx;       arith = 1'b1; end
      OP_DEC:           begin ext = ax - one;      arith = 1'b1; end
      OP_AND, OP_AND1:  res = a & b;
      OP_OR,  OP_OR1:   res = a | b;
      OP_XOR, OP_XOR1:  res = a ^ b;
      OP_CMP, OP_CMP1:  res = ~b;
      default:          res = a;
    endcase
    if (arith) res = ext[W-1:0];
  end

  assign c            = iter_sel ? iter_c : res;
  assign flags.sign   = c[W-1];
  assign flags.zero   = ~|c;
  assign flags.parity = ^c;
  assign flags.carry  = iter_sel ? iter_cy : (arith & ext[W]);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready issue, IDLE->EXEC->DONE FSM, registered status
// feeding ADC/SBB carry. ALU_MUL_EN adds the shift-add multiplier on opcode 14.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            opcode,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] C,
  output logic [DATA_WIDTH-1:0] C_hi,
  output logic [3:0]            status
);

  localparam int W       = DATA_WIDTH;
  localparam int SHAMT_W = $clog2(W);
  localparam int CNT_W   = SHAMT_W + 1;

  state_t           state, state_nx;
  logic [4:0]       op_q;
  logic [W-1:0]     a_q, b_q, wr, hi;
  logic             sh_cy, xfer, iter_sel, iter_cy;
  logic [CNT_W-1:0] cnt;
  logic [W:0]       mul_sum;
  logic [W-1:0]     core_c;
  flags_t           core_flags;

  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (xfer) state_nx = S_EXEC;
      S_EXEC:  if (cnt == '0) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_IDLE);
  end

  // Multiplier step: wr holds the multiplier bits, shifted out LSB-first while
  // the product's low half shifts in from the top.
  assign mul_sum = {1'b0, hi} + (wr[0] ? {1'b0, a_q} : {(W+1){1'b0}});

  always_ff @(posedge clk) begin
    if (reset) begin
      done   <= 1'b0;
      C      <= '0;
      C_hi   <= '0;
      status <= '0;
      op_q   <= OP_LD;
      a_q    <= '0;
      b_q    <= '0;
      wr     <= '0;
      hi     <= '0;
      sh_cy  <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (xfer) begin
          op_q  <= opcode;
          a_q   <= A;
          b_q   <= B;
          hi    <= '0;
          sh_cy <= 1'b0;
          wr    <= is_mul(opcode) ? B : A;
          if (is_mul(opcode))        cnt <= CNT_W'(W);
          else if (is_shift(opcode)) cnt <= {1'b0, B[SHAMT_W-1:0]};
          else                       cnt <= '0;
        end
        S_EXEC: if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
          if (is_mul(op_q)) begin
            hi <= mul_sum[W:1];
            wr <= {mul_sum[0], wr[W-1:1]};
          end else begin
            case (op_q)
              OP_RSH:  begin wr <= {1'b0, wr[W-1:1]};     sh_cy <= wr[0];   end
              OP_ASR:  begin wr <= {wr[W-1], wr[W-1:1]};  sh_cy <= wr[0];   end
              OP_LSH:  begin wr <= {wr[W-2:0], 1'b0};     sh_cy <= wr[W-1]; end
              OP_ROL:  begin wr <= {wr[W-2:0], wr[W-1]};  sh_cy <= wr[W-1]; end
              default: ;
            endcase
          end
        end
        S_DONE: begin
          done   <= 1'b1;
          C      <= core_c;
          C_hi   <= is_mul(op_q) ? hi : '0;
          status <= core_flags;
        end
        default: ;
      endcase
    end
  end

  assign iter_sel = is_shift(op_q) || is_mul(op_q);
  assign iter_cy  = is_mul(op_q) ? (hi != '0) : sh_cy;

  alu_mc_core #(.DATA_WIDTH(W)) u_core (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .cf      (status[CARRY]),
    .iter_sel(iter_sel),
    .iter_c  (wr),
    .iter_cy (iter_cy),
    .c       (core_c),
    .flags   (core_flags)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at DATA_WIDTH=8; expected values hand-computed.
module tb_alu_mc;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, done;
  logic [4:0] opcode;
  logic [7:0] A, B, C, C_hi;
  logic [3:0] status;
  int         total = 0;
  int         bad   = 0;

  alu_mc #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .A(A), .B(B), .done(done), .C(C), .C_hi(C_hi), .status(status)
  );

  always #5 clk = ~clk;

  // Issues one op (caller is #1 after an edge with DUT idle) and returns edges until done.
  task automatic run_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
    opcode = op; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; opcode = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (C !== 8'h00)       begin bad++; $display("FAIL reset_c got=%h exp=00", C); end
    total++; if (C_hi !== 8'h00)    begin bad++; $display("FAIL reset_chi got=%h exp=00", C_hi); end
    total++; if (status !== 4'b0000) begin bad++; $display("FAIL reset_status got=%b exp=0000", status); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    int lat;
    run_op(5'h02, 8'd200, 8'd100, lat);
    total++; if (lat !== 2)          begin bad++; $display("FAIL add_lat got=%0d exp=2", lat); end
    total++; if (C !== 8'd44)        begin bad++; $display("FAIL add_c got=%h exp=2c", C); end
    total++; if (status !== 4'b0011) begin bad++; $display("FAIL add_status got=%b exp=0011", status); end
    total++; if (C_hi !== 8'h00)     begin bad++; $display("FAIL add_chi got=%h exp=00", C_hi); end
    run_op(5'h03, 8'd1, 8'd1, lat);
    total++; if (C !== 8'd3)         begin bad++; $display("FAIL adc_c got=%h exp=03", C); end
    total++; if (status !== 4'b0000) begin bad++; $display("FAIL adc_status got=%b exp=0000", status); end
    run_op(5'h05, 8'd5, 8'd5, lat);
    total++; if (C !== 8'h00)        begin bad++; $display("FAIL sub0_c got=%h exp=00", C); end
    total++; if (status !== 4'b0100) begin bad++; $display("FAIL sub0_status got=%b exp=0100", status); end
    run_op(5'h05, 8'd3, 8'd5, lat);
    total++; if (C !== 8'hFE)        begin bad++; $display("FAIL subneg_c got=%h exp=fe", C); end
    total++; if (status !== 4'b1011) begin bad++; $display("FAIL subneg_status got=%b exp=1011", status); end
    run_op(5'h04, 8'd3, 8'd1, lat);
    total++; if (C !== 8'h01)        begin bad++; $display("FAIL sbb_c got=%h exp=01", C); end
    total++; if (status !== 4'b0010) begin bad++; $display("FAIL sbb_status got=%b exp=0010", status); end
    run_op(5'h06, 8'h00, 8'h00, lat);
    total++; if (C !== 8'hFF)        begin bad++; $display("FAIL dec_c got=%h exp=ff", C); end
    total++; if (status !== 4'b1001) begin bad++; $display("FAIL dec_status got=%b exp=1001", status); end
    run_op(5'h01, 8'hFF, 8'h00, lat);
    total++; if (C !== 8'h00)        begin bad++; $display("FAIL inc_c got=%h exp=00", C); end
    total++; if (status !== 4'b0101) begin bad++; $display("FAIL inc_status got=%b exp=0101", status); end
  endtask

  task automatic test_logic();
    int lat;
    run_op(5'h09, 8'hF0, 8'h3C, lat);
    total++; if (C !== 8'h30)        begin bad++; $display("FAIL and_c got=%h exp=30", C); end
    total++; if (status !== 4'b0000) begin bad++; $display("FAIL and_status got=%b exp=0000", status); end
    run_op(5'h0C, 8'hF0, 8'h31, lat);
    total++; if (C !== 8'hC1)        begin bad++; $display("FAIL xor_c got=%h exp=c1", C); end
    total++; if (status !== 4'b1010) begin bad++; $display("FAIL xor_status got=%b exp=1010", status); end
    run_op(5'h0E, 8'h55, 8'h0F, lat);
    total++; if (C !== 8'hF0)        begin bad++; $display("FAIL cmp_c got=%h exp=f0", C); end
    total++; if (status !== 4'b1000) begin bad++; $display("FAIL cmp_status got=%b exp=1000", status); end
    run_op(5'h1F, 8'h7E, 8'h11, lat);
    total++; if (C !== 8'h7E)        begin bad++; $display("FAIL undef_c got=%h exp=7e", C); end
    total++; if (lat !== 2)          begin bad++; $display("FAIL undef_lat got=%0d exp=2", lat); end
  endtask

  task automatic test_shift();
    int lat;
    run_op(5'h18, 8'h81, 8'd3, lat);
    total++; if (lat !== 5)          begin bad++; $display("FAIL lsh_lat got=%0d exp=5", lat); end
    total++; if (C !== 8'h08)        begin bad++; $display("FAIL lsh_c got=%h exp=08", C); end
    total++; if (status[0] !== 1'b0) begin bad++; $display("FAIL lsh_carry got=%b exp=0", status[0]); end
    run_op(5'h11, 8'h80, 8'd2, lat);
    total++; if (C !== 8'hE0)        begin bad++; $display("FAIL asr_c got=%h exp=e0", C); end
    total++; if (status !== 4'b1010) begin bad++; $display("FAIL asr_status got=%b exp=1010", status); end
    total++; if (lat !== 4)          begin bad++; $display("FAIL asr_lat got=%0d exp=4", lat); end
    run_op(5'h10, 8'h5A, 8'd0, lat);
    total++; if (C !== 8'h5A)        begin bad++; $display("FAIL rsh0_c got=%h exp=5a", C); end
    total++; if (lat !== 2)          begin bad++; $display("FAIL rsh0_lat got=%0d exp=2", lat); end
    total++; if (status !== 4'b0000) begin bad++; $display("FAIL rsh0_status got=%b exp=0000", status); end
    run_op(5'h10, 8'h81, 8'd1, lat);
    total++; if (C !== 8'h40)        begin bad++; $display("FAIL rsh1_c got=%h exp=40", C); end
    total++; if (status !== 4'b0011) begin bad++; $display("FAIL rsh1_status got=%b exp=0011", status); end
    run_op(5'h19, 8'h81, 8'd1, lat);
    total++; if (C !== 8'h03)        begin bad++; $display("FAIL rol_c got=%h exp=03", C); end
    total++; if (status !== 4'b0001) begin bad++; $display("FAIL rol_status got=%b exp=0001", status); end
    run_op(5'h18, 8'h01, 8'h0F, lat);
    total++; if (C !== 8'h80)        begin bad++; $display("FAIL lsh7_c got=%h exp=80", C); end
    total++; if (lat !== 9)          begin bad++; $display("FAIL lsh7_lat got=%0d exp=9", lat); end
  endtask

  task automatic test_mul();
    int lat;
    run_op(5'h14, 8'd200, 8'd3, lat);
`ifdef ALU_MUL_EN
    total++; if (C !== 8'h58)        begin bad++; $display("FAIL mul_c got=%h exp=58", C); end
    total++; if (C_hi !== 8'h02)     begin bad++; $display("FAIL mul_chi got=%h exp=02", C_hi); end
    total++; if (status !== 4'b0011) begin bad++; $display("FAIL mul_status got=%b exp=0011", status); end
    total++; if (lat !== 10)         begin bad++; $display("FAIL mul_lat got=%0d exp=10", lat); end
    run_op(5'h14, 8'hFF, 8'hFF, lat);
    total++; if (C !== 8'h01)        begin bad++; $display("FAIL mulmax_c got=%h exp=01", C); end
    total++; if (C_hi !== 8'hFE)     begin bad++; $display("FAIL mulmax_chi got=%h exp=fe", C_hi); end
    run_op(5'h14, 8'd7, 8'd9, lat);
    total++; if (C !== 8'd63)        begin bad++; $display("FAIL mulsm_c got=%h exp=3f", C); end
    total++; if (status !== 4'b0000) begin bad++; $display("FAIL mulsm_status got=%b exp=0000", status); end
`else
    total++; if (C !== 8'd200)       begin bad++; $display("FAIL mul_c got=%h exp=c8", C); end
    total++; if (C_hi !== 8'h00)     begin bad++; $display("FAIL mul_chi got=%h exp=00", C_hi); end
    total++; if (status !== 4'b1010) begin bad++; $display("FAIL mul_status got=%b exp=1010", status); end
    total++; if (lat !== 2)          begin bad++; $display("FAIL mul_lat got=%0d exp=2", lat); end
`endif
  endtask

  // in_valid held through EXEC must not be captured; result must hold after done.
  task automatic test_back_to_back();
    int lat;
    opcode = 5'h18; A = 8'h01; B = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    opcode = 5'h02; A = 8'hFF; B = 8'hFF;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL exec_ready got=%b exp=0", in_ready); end
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    in_valid = 1'b0;
    total++; if (lat !== 5)          begin bad++; $display("FAIL b2b_lat got=%0d exp=5", lat); end
    total++; if (C !== 8'h08)        begin bad++; $display("FAIL b2b_c got=%h exp=08", C); end
    total++; if (status !== 4'b0010) begin bad++; $display("FAIL b2b_status got=%b exp=0010", status); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL done_pulse got=%b exp=0", done); end
    total++; if (C !== 8'h08)        begin bad++; $display("FAIL hold_c got=%h exp=08", C); end
  endtask

  task automatic test_midop_reset();
    int dones = 0;
`ifdef ALU_MUL_EN
    opcode = 5'h14; A = 8'd200; B = 8'd3;
`else
    opcode = 5'h18; A = 8'h01; B = 8'd7;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    opcode = 5'h02; A = 8'd1; B = 8'd1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
    total++; if (status !== 4'b0000) begin bad++; $display("FAIL midrst_status got=%b exp=0000", status); end
    total++; if (C !== 8'h00)        begin bad++; $display("FAIL midrst_c got=%h exp=00", C); end
    for (int n = 0; n < 16; n++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++; if (dones !== 0)        begin bad++; $display("FAIL midrst_dones got=%0d exp=0", dones); end
  endtask

  initial begin
    in_valid = 1'b0;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_mul();
    test_back_to_back();
    test_midop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
